fetch_prefetch: RTL and testbench

FETCH_PREFETCH -- requirements
Module: fetch_prefetch

---
 rtl/fetch_prefetch_if.sv | 24 ++
 rtl/fetch_prefetch.sv | 104 ++++++++++
 tb/tb_fetch_prefetch.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_if.sv
// Consumer and memory-bus signals of the instruction prefetcher.
// The master modport is the prefetcher side. The slave modport is the environment side.
interface fetch_prefetch_if;
  logic        i_jump;
  logic [31:0] i_jump_pc;
  logic        i_pop;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instruction;
  logic        o_bus_request;
  logic [31:0] o_bus_address;
  logic [31:0] i_bus_rdata;
  logic        i_bus_ready;

  modport master (
    input  i_jump, i_jump_pc, i_pop, i_bus_rdata, i_bus_ready,
    output o_valid, o_pc, o_instruction, o_bus_request, o_bus_address
  );

  modport slave (
    output i_jump, i_jump_pc, i_pop, i_bus_rdata, i_bus_ready,
    input  o_valid, o_pc, o_instruction, o_bus_request, o_bus_address
  );
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction prefetch buffer: fetches sequential words into a small FIFO.
// It keeps at most one bus transfer in flight and flushes the FIFO on a redirect.
module fetch_prefetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          DEPTH        = 4
) (
  input logic              i_clock,
  input logic              i_reset,
  fetch_prefetch_if.master fp
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {IDLE, REQUEST, DISCARD} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          push, pop;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] data_mem [DEPTH];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fp.i_jump && (count_q < DEPTH_C)) state_d = REQUEST;
      end
      REQUEST: begin
        if (fp.i_bus_ready) begin
          state_d = IDLE;
          push    = !fp.i_jump;
        end else if (fp.i_jump) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        // The orphaned response retires the transfer even if another redirect lands with it.
        if (fp.i_bus_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (push)      fetch_pc_d = fetch_pc_q + 32'd4;
    if (fp.i_jump) fetch_pc_d = {fp.i_jump_pc[31:2], 2'b00};
  end

  assign pop = fp.i_pop && (count_q != '0) && !fp.i_jump;

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (fp.i_jump) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_VECTOR;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage is deliberately left out of reset; entries are only read while counted valid.
  always_ff @(posedge i_clock) begin
    if (push && !i_reset) begin
      pc_mem[wr_ptr_q]   <= fetch_pc_q;
      data_mem[wr_ptr_q] <= fp.i_bus_rdata;
    end
  end

  assign fp.o_valid       = (count_q != '0);
  assign fp.o_pc          = pc_mem[rd_ptr_q];
  assign fp.o_instruction = data_mem[rd_ptr_q];
  assign fp.o_bus_request = (state_q == REQUEST);
  assign fp.o_bus_address = fetch_pc_q;
endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: directed table, corner sequences, and a randomized run.
// The randomized run is checked against a queue model.
module tb_fetch_prefetch;
  logic clk = 1'b0;
  logic rst, rst2;
  always #5 clk = ~clk;

  fetch_prefetch_if fa();
  fetch_prefetch_if fb();

  fetch_prefetch #(.RESET_VECTOR(32'h0000_0000), .DEPTH(4)) dut (
    .i_clock(clk), .i_reset(rst), .fp(fa));
  fetch_prefetch #(.RESET_VECTOR(32'h0000_0080), .DEPTH(8)) dut_rv (
    .i_clock(clk), .i_reset(rst2), .fp(fb));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        pop;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic vec_t mk(input logic pop, input logic ready, input logic req,
                              input logic [31:0] addr, input logic valid,
                              input logic [31:0] pc);
    vec_t v;
    v.pop = pop; v.ready = ready; v.exp_req = req;
    v.exp_addr = addr; v.exp_valid = valid; v.exp_pc = pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string name, input logic [31:0] pc);
    chk({name, "_valid"}, 32'(fa.o_valid), 32'd1);
    chk({name, "_pc"}, fa.o_pc, pc);
    chk({name, "_instr"}, fa.o_instruction, rom(pc));
  endtask

  vec_t   tbl[17];
  entry_t q[$];
  logic [31:0] model_pc, jpc, laddr;
  logic   owe, do_jump, do_pop;
  int     cnt, lat, popped, pop_pct;

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    fa.i_jump = 1'b0; fa.i_jump_pc = '0; fa.i_pop = 1'b0;
    fa.i_bus_ready = 1'b0; fa.i_bus_rdata = '0;
    fb.i_jump = 1'b0; fb.i_jump_pc = '0; fb.i_pop = 1'b0;
    fb.i_bus_ready = 1'b0; fb.i_bus_rdata = '0;

    // Startup with a 1-cycle ROM, then a single pop from a full buffer.
    tbl[0]  = mk(0, 0, 0, 32'h00, 0, 32'h0);
    tbl[1]  = mk(0, 0, 1, 32'h00, 0, 32'h0);
    tbl[2]  = mk(0, 1, 1, 32'h00, 0, 32'h0);
    tbl[3]  = mk(0, 0, 0, 32'h04, 1, 32'h0);
    tbl[4]  = mk(0, 0, 1, 32'h04, 1, 32'h0);
    tbl[5]  = mk(0, 1, 1, 32'h04, 1, 32'h0);
    tbl[6]  = mk(0, 0, 0, 32'h08, 1, 32'h0);
    tbl[7]  = mk(0, 0, 1, 32'h08, 1, 32'h0);
    tbl[8]  = mk(0, 1, 1, 32'h08, 1, 32'h0);
    tbl[9]  = mk(0, 0, 0, 32'h0C, 1, 32'h0);
    tbl[10] = mk(0, 0, 1, 32'h0C, 1, 32'h0);
    tbl[11] = mk(0, 1, 1, 32'h0C, 1, 32'h0);
    tbl[12] = mk(0, 0, 0, 32'h10, 1, 32'h0);
    tbl[13] = mk(0, 0, 0, 32'h10, 1, 32'h0);
    tbl[14] = mk(1, 0, 0, 32'h10, 1, 32'h0);
    tbl[15] = mk(0, 0, 0, 32'h10, 1, 32'h4);
    tbl[16] = mk(0, 0, 1, 32'h10, 1, 32'h4);

    tick; tick;
    chk("reset_req", 32'(fa.o_bus_request), 32'd0);
    chk("reset_valid", 32'(fa.o_valid), 32'd0);
    rst = 1'b0; rst2 = 1'b0;

    for (int i = 0; i < 17; i++) begin
      chk($sformatf("tbl%0d_req", i), 32'(fa.o_bus_request), 32'(tbl[i].exp_req));
      chk($sformatf("tbl%0d_addr", i), fa.o_bus_address, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_valid", i), 32'(fa.o_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_pc", i), fa.o_pc, tbl[i].exp_pc);
        chk($sformatf("tbl%0d_instr", i), fa.o_instruction, rom(tbl[i].exp_pc));
      end
      fa.i_pop = tbl[i].pop;
      fa.i_bus_ready = tbl[i].ready;
      fa.i_bus_rdata = tbl[i].ready ? rom(fa.o_bus_address) : 32'hDEAD_BEEF;
      tick;
    end
    fa.i_pop = 1'b0; fa.i_bus_ready = 1'b0;

    // Redirect while a request waits on the bus; the late response is dropped.
    fa.i_jump = 1'b1; fa.i_jump_pc = 32'h0000_0103;
    tick;
    fa.i_jump = 1'b0;
    chk("jmp_valid", 32'(fa.o_valid), 32'd0);
    chk("jmp_req", 32'(fa.o_bus_request), 32'd0);
    fa.i_bus_ready = 1'b1; fa.i_bus_rdata = 32'hBAD0_BAD0;
    tick;
    fa.i_bus_ready = 1'b0;
    chk("disc_valid", 32'(fa.o_valid), 32'd0);
    chk("disc_req", 32'(fa.o_bus_request), 32'd0);
    tick;
    chk("jmp_newreq", 32'(fa.o_bus_request), 32'd1);
    chk("jmp_newaddr", fa.o_bus_address, 32'h100);
    fa.i_bus_ready = 1'b1; fa.i_bus_rdata = rom(32'h100);
    tick;
    fa.i_bus_ready = 1'b0;
    chk_head("jmp_first", 32'h100);

    // Redirect coinciding with a bus response and a pop.
    tick;
    chk("j3_req", 32'(fa.o_bus_request), 32'd1);
    chk("j3_addr", fa.o_bus_address, 32'h104);
    fa.i_bus_ready = 1'b1; fa.i_bus_rdata = rom(32'h104);
    fa.i_pop = 1'b1; fa.i_jump = 1'b1; fa.i_jump_pc = 32'h0000_0200;
    tick;
    fa.i_bus_ready = 1'b0; fa.i_pop = 1'b0; fa.i_jump = 1'b0;
    chk("j3_valid", 32'(fa.o_valid), 32'd0);
    chk("j3_idle", 32'(fa.o_bus_request), 32'd0);
    tick;
    chk("j3_newreq", 32'(fa.o_bus_request), 32'd1);
    chk("j3_newaddr", fa.o_bus_address, 32'h200);
    fa.i_bus_ready = 1'b1; fa.i_bus_rdata = rom(32'h200);
    tick;
    fa.i_bus_ready = 1'b0;
    chk_head("j3_first", 32'h200);

    // Reset in the middle of a transfer on the RESET_VECTOR=0x80 instance.
    chk("rv_req", 32'(fb.o_bus_request), 32'd1);
    chk("rv_addr", fb.o_bus_address, 32'h80);
    fb.i_bus_ready = 1'b1; fb.i_bus_rdata = rom(32'h80);
    tick;
    fb.i_bus_ready = 1'b0;
    tick;
    chk("rv_req2", 32'(fb.o_bus_request), 32'd1);
    chk("rv_addr2", fb.o_bus_address, 32'h84);
    rst2 = 1'b1; fb.i_jump = 1'b1; fb.i_jump_pc = 32'h300;
    tick;
    chk("rv_rst_req", 32'(fb.o_bus_request), 32'd0);
    chk("rv_rst_valid", 32'(fb.o_valid), 32'd0);
    fb.i_bus_ready = 1'b1; fb.i_bus_rdata = 32'h1234_5678;
    tick;
    fb.i_jump = 1'b0;
    rst2 = 1'b0;
    chk("rv_late_valid", 32'(fb.o_valid), 32'd0);
    tick;
    fb.i_bus_ready = 1'b0;
    chk("rv_idle_valid", 32'(fb.o_valid), 32'd0);
    tick;
    chk("rv_rel_req", 32'(fb.o_bus_request), 32'd1);
    chk("rv_rel_addr", fb.o_bus_address, 32'h80);

    // Randomized run against the queue model; phase 0 is the continuous-pop check.
    rst = 1'b1; tick; tick; rst = 1'b0;
    q.delete(); model_pc = 32'h0; owe = 1'b0; cnt = 0; laddr = '0; popped = 0;
    for (int phase = 0; phase < 2; phase++) begin
      for (int c = 0; c < 1500; c++) begin
        chk("rnd_valid", 32'(fa.o_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
          chk("rnd_pc", fa.o_pc, q[0].pc);
          chk("rnd_instr", fa.o_instruction, q[0].data);
        end
        if (fa.o_bus_request) begin
          chk("rnd_addr", fa.o_bus_address, model_pc);
          chk("rnd_notfull", 32'(q.size() < 4), 32'd1);
        end
        lat     = (phase == 0) ? 1 : int'($urandom_range(1, 4));
        pop_pct = (phase == 0) ? 100 : 55;
        do_pop  = ($urandom_range(0, 99) < pop_pct);
        do_jump = (phase != 0) && ($urandom_range(0, 99) < 4);
        jpc     = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
        fa.i_bus_ready = 1'b0;
        fa.i_bus_rdata = $urandom;
        if (owe) begin
          if (cnt == 0) begin
            fa.i_bus_ready = 1'b1;
            fa.i_bus_rdata = rom(laddr);
            owe = 1'b0;
          end else cnt--;
        end else if (fa.o_bus_request) begin
          owe = 1'b1; laddr = fa.o_bus_address; cnt = lat - 1;
        end
        fa.i_pop = do_pop; fa.i_jump = do_jump; fa.i_jump_pc = jpc;
        if (do_jump) begin
          q.delete();
          model_pc = {jpc[31:2], 2'b00};
        end else begin
          if (do_pop && q.size() != 0) begin
            void'(q.pop_front());
            if (phase == 0) popped++;
          end
          if (fa.o_bus_request && fa.i_bus_ready) begin
            q.push_back('{pc: model_pc, data: rom(model_pc)});
            model_pc = model_pc + 32'd4;
          end
        end
        tick;
      end
      if (phase == 0) chk("stream_count_gt8", 32'(popped > 8), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
